conv3x3_stream: RTL and testbench

- Downstream consumer of the frame BRAM controller's processing port.
- Requests pixel triples one pulse at a time. Each triple is 3 horizontally contiguous pixels of one row; successive triples walk down one column strip.
- Builds a sliding 3x3 window, multiplies it by a signed 3x3 kernel, and emits one saturated 8-bit output pixel per window position.
- Tracks strip and frame boundaries, so the frame is processed as (IMAGE_WIDTH-2) strips × (IMAGE_HEIGHT-2) outputs.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv3x3_stream_mac9.sv | 71 +++++++
 rtl/conv3x3_stream.sv | 138 +++++++++++++
 tb/tb_conv3x3_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 streaming convolution: FSM encoding,
// datapath widths and the output saturation helper.
package conv_pkg;

   localparam int unsigned PIX_W   = 8;
   localparam int unsigned COEF_W  = 8;
   localparam int unsigned SHIFT_W = 4;
   localparam int unsigned NTAPS   = 9;
   localparam int unsigned PROD_W  = PIX_W + COEF_W + 1;
   localparam int unsigned ACC_W   = PROD_W + 4;

   localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(2 ** PIX_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   // Clamp a signed accumulator into the unsigned pixel range.
   function automatic logic [PIX_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
      if (v[ACC_W-1]) return '0;
      if (v > PIX_MAX) return '1;
      return v[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/conv3x3_stream_mac9.sv
// Two-stage 3x3 multiply / sum / shift / saturate pipeline.
// Optional CONV_ROUND_EN adds round-half-up before the right shift.
module conv_mac9
   import conv_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_launch,
   input  logic [NTAPS*PIX_W-1:0]   i_window,
   input  logic [NTAPS*COEF_W-1:0]  i_kernel,
   input  logic [SHIFT_W-1:0]       i_shift,
   output logic                     o_pipe_busy,
   output logic                     o_valid,
   output logic [PIX_W-1:0]         o_pixel
);

   logic signed [PROD_W-1:0] prod_q [NTAPS];
   logic signed [PROD_W-1:0] prod_d [NTAPS];
   logic signed [PROD_W-1:0] op_pix, op_coef;
   logic signed [ACC_W-1:0]  acc, shifted;
   logic                     v1_q, v1_d;
   logic                     valid_q, valid_d;
   logic [PIX_W-1:0]         pixel_q, pixel_d;

   // Stage 1: pixels are unsigned, so a zero MSB keeps them positive in the signed multiply.
   always_comb begin
      v1_d    = i_launch;
      op_pix  = '0;
      op_coef = '0;
      for (int t = 0; t < NTAPS; t++) begin
         op_pix    = PROD_W'($signed({1'b0, i_window[t*PIX_W +: PIX_W]}));
         op_coef   = PROD_W'($signed(i_kernel[t*COEF_W +: COEF_W]));
         prod_d[t] = i_launch ? op_pix * op_coef : prod_q[t];
      end
   end

   // Stage 2: sum, shift, clamp.
   always_comb begin
      acc = '0;
      for (int t = 0; t < NTAPS; t++) begin
         acc = acc + ACC_W'(prod_q[t]);
      end
`ifdef CONV_ROUND_EN
      if (i_shift != '0) begin
         acc = acc + (ACC_W'(1) << (i_shift - SHIFT_W'(1)));
      end
`endif
      shifted = acc >>> i_shift;
      valid_d = v1_q;
      pixel_d = v1_q ? saturate(shifted) : pixel_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int t = 0; t < NTAPS; t++) prod_q[t] <= '0;
         v1_q    <= 1'b0;
         valid_q <= 1'b0;
         pixel_q <= '0;
      end else begin
         for (int t = 0; t < NTAPS; t++) prod_q[t] <= prod_d[t];
         v1_q    <= v1_d;
         valid_q <= valid_d;
         pixel_q <= pixel_d;
      end
   end

   assign o_pipe_busy = v1_q;
   assign o_valid     = valid_q;
   assign o_pixel     = pixel_q;

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: requests pixel triples strip by strip, keeps a
// sliding window and feeds conv_mac9. Rounding option: CONV_ROUND_EN.
module conv3x3_stream
   import conv_pkg::*;
#(
   parameter int unsigned PIX_WIDTH    = PIX_W,
   parameter int unsigned COEF_WIDTH   = COEF_W,
   parameter int unsigned IMAGE_WIDTH  = 10,
   parameter int unsigned IMAGE_HEIGHT = 10,
   parameter int unsigned SHIFT_WIDTH  = SHIFT_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_start,
   input  logic [9*COEF_WIDTH-1:0] i_kernel,
   input  logic [SHIFT_WIDTH-1:0]  i_shift,
   output logic                    o_read_request,
   input  logic                    i_valid_data,
   input  logic [PIX_WIDTH-1:0]    i_pix0,
   input  logic [PIX_WIDTH-1:0]    i_pix1,
   input  logic [PIX_WIDTH-1:0]    i_pix2,
   output logic                    o_valid,
   output logic [PIX_WIDTH-1:0]    o_pixel,
   output logic                    o_busy,
   output logic                    o_frame_done
);

   localparam int unsigned ROW_W   = $clog2(IMAGE_HEIGHT + 1);
   localparam int unsigned STRIP_W = $clog2(IMAGE_WIDTH);
   localparam int unsigned WIN_W   = NTAPS * PIX_W;

   state_e                    state_q, state_d;
   logic [ROW_W-1:0]          row_cnt_q, row_cnt_d, row_inc;
   logic [STRIP_W-1:0]        strip_cnt_q, strip_cnt_d;
   logic [WIN_W-1:0]          win_q, win_d;
   logic [NTAPS*COEF_W-1:0]   kernel_q, kernel_d;
   logic [SHIFT_W-1:0]        shift_q, shift_d;
   logic                      launch_q, launch_d;
   logic                      req_q, req_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      pipe_busy;

   assign row_inc = row_cnt_q + ROW_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state plus counter/window updates; window row 0 is the oldest row.
   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      strip_cnt_d = strip_cnt_q;
      win_d       = win_q;
      kernel_d    = kernel_q;
      shift_d     = shift_q;
      launch_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               kernel_d    = i_kernel;
               shift_d     = i_shift;
               row_cnt_d   = '0;
               strip_cnt_d = '0;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: state_d = ST_WAIT;
         ST_WAIT: begin
            if (i_valid_data) begin
               win_d     = {i_pix2, i_pix1, i_pix0, win_q[WIN_W-1:3*PIX_W]};
               row_cnt_d = row_inc;
               launch_d  = (row_inc >= ROW_W'(3));
               state_d   = ST_REQ;
               if (row_inc == ROW_W'(IMAGE_HEIGHT)) begin
                  row_cnt_d   = '0;
                  strip_cnt_d = strip_cnt_q + STRIP_W'(1);
                  if (strip_cnt_q == STRIP_W'(IMAGE_WIDTH - 3)) state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (!launch_q && !pipe_busy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake/status outputs, registered so they line up with the state they describe.
   always_comb begin
      req_d  = (state_d == ST_REQ);
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_cnt_q   <= '0;
         strip_cnt_q <= '0;
         win_q       <= '0;
         kernel_q    <= '0;
         shift_q     <= '0;
         launch_q    <= 1'b0;
         req_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         row_cnt_q   <= row_cnt_d;
         strip_cnt_q <= strip_cnt_d;
         win_q       <= win_d;
         kernel_q    <= kernel_d;
         shift_q     <= shift_d;
         launch_q    <= launch_d;
         req_q       <= req_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   conv_mac9 u_mac (
      .clk         (clk),
      .reset       (reset),
      .i_launch    (launch_q),
      .i_window    (win_q),
      .i_kernel    (kernel_q),
      .i_shift     (shift_q),
      .o_pipe_busy (pipe_busy),
      .o_valid     (o_valid),
      .o_pixel     (o_pixel)
   );

   assign o_read_request = req_q;
   assign o_busy         = busy_q;
   assign o_frame_done   = done_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomised bench for conv3x3_stream against a direct per-window convolution model.
module tb_conv3x3_stream;

   localparam int unsigned PW   = 8;
   localparam int unsigned CW   = 8;
   localparam int unsigned SW   = 4;
   localparam int unsigned IW   = 10;
   localparam int unsigned IH   = 10;
   localparam int          NOUT = (IW - 2) * (IH - 2);

   logic            clk = 1'b0;
   logic            reset;
   logic            i_start;
   logic [9*CW-1:0] i_kernel;
   logic [SW-1:0]   i_shift;
   logic            o_read_request;
   logic            i_valid_data;
   logic [PW-1:0]   i_pix0, i_pix1, i_pix2;
   logic            o_valid;
   logic [PW-1:0]   o_pixel;
   logic            o_busy;
   logic            o_frame_done;

   conv3x3_stream dut (
      .clk            (clk),
      .reset          (reset),
      .i_start        (i_start),
      .i_kernel       (i_kernel),
      .i_shift        (i_shift),
      .o_read_request (o_read_request),
      .i_valid_data   (i_valid_data),
      .i_pix0         (i_pix0),
      .i_pix1         (i_pix1),
      .i_pix2         (i_pix2),
      .o_valid        (o_valid),
      .o_pixel        (o_pixel),
      .o_busy         (o_busy),
      .o_frame_done   (o_frame_done)
   );

   always #5 clk = ~clk;

   int img [IH][IW];
   int kern [9];
   int shamt;
   int exp_q [$];
   int got_q [$];
   int n_checks = 0;
   int n_fail   = 0;
   int req_cnt  = 0;
   int gen      = 0;
   int n_out, n_extra, n_done;
   bit hold_first = 1'b0;
   bit spur_en    = 1'b0;

   task automatic chk(input string tag, input int got, input int exp_v);
      n_checks++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp_v, $time);
      end
   endtask

   // Reference: direct 3x3 dot product over the frame, shifted and clamped.
   function automatic int ref_pixel(input int s, input int r);
      int acc = 0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            acc += img[r+dr][s+dc] * kern[dr*3+dc];
`ifdef CONV_ROUND_EN
      if (shamt > 0) acc += (1 << (shamt - 1));
`endif
      acc = acc >>> shamt;
      if (acc < 0) acc = 0;
      if (acc > 255) acc = 255;
      return acc;
   endfunction

   function automatic int got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return -1;
   endfunction

   task automatic fill_ramp();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++) img[r][c] = r * 10 + c;
   endtask

   task automatic fill_const(input int v);
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++) img[r][c] = v;
   endtask

   task automatic fill_rand();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++) img[r][c] = int'($urandom_range(255));
   endtask

   task automatic set_kern_all(input int v);
      for (int t = 0; t < 9; t++) kern[t] = v;
   endtask

   task automatic start_frame();
      exp_q.delete();
      for (int s = 0; s < IW - 2; s++)
         for (int r = 0; r < IH - 2; r++) exp_q.push_back(ref_pixel(s, r));
      got_q.delete();
      n_out = 0; n_extra = 0; n_done = 0;
      req_cnt = 0;
      gen++;
      for (int t = 0; t < 9; t++) i_kernel[t*CW +: CW] = CW'(kern[t]);
      i_shift = SW'(shamt);
      @(posedge clk); #1;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      chk("busy_rise", int'(o_busy), 1);
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk);
         if (o_frame_done) seen = 1'b1;
      end
      chk({tag, "_done_seen"}, int'(seen), 1);
      chk({tag, "_busy_fall"}, int'(o_busy), 0);
      chk({tag, "_out_count"}, n_out, NOUT);
      chk({tag, "_extra_out"}, n_extra, 0);
      chk({tag, "_exp_left"}, exp_q.size(), 0);
      repeat (3) @(negedge clk);
      chk({tag, "_done_pulses"}, n_done, 1);
   endtask

   // Output monitor: every valid pixel is compared in order with the model.
   always @(negedge clk) begin
      if (o_valid) begin
         n_out++;
         got_q.push_back(int'(o_pixel));
         if (exp_q.size() > 0) chk("pixel", int'(o_pixel), exp_q.pop_front());
         else n_extra++;
      end
      if (o_frame_done) n_done++;
   end

   // Upstream responder: answers each request 1..5 cycles later with the matching triple.
   initial begin
      int idx, g, d, sp, rw, nr, nv;
      i_valid_data = 1'b0;
      i_pix0 = '0; i_pix1 = '0; i_pix2 = '0;
      @(posedge clk); #1;
      forever begin
         if (o_read_request) begin
            idx = req_cnt;
            req_cnt++;
            g = gen;
            d = int'($urandom_range(5, 1));
            if (hold_first && idx == 0) begin
               nr = 0; nv = 0;
               repeat (20) begin
                  @(posedge clk); #1;
                  nr += int'(o_read_request);
                  nv += int'(o_valid);
               end
               chk("hold_no_req", nr, 0);
               chk("hold_no_out", nv, 0);
               d = 0;
            end else if (spur_en) begin
               i_valid_data = 1'b1;
               i_pix0 = PW'($urandom); i_pix1 = PW'($urandom); i_pix2 = PW'($urandom);
               @(posedge clk); #1;
               i_valid_data = 1'b0;
               d = d - 1;
            end
            repeat (d) begin @(posedge clk); #1; end
            if (g == gen) begin
               sp = idx / IH;
               rw = idx % IH;
               i_pix0 = PW'(img[rw][sp]);
               i_pix1 = PW'(img[rw][sp+1]);
               i_pix2 = PW'(img[rw][sp+2]);
               i_valid_data = 1'b1;
               @(posedge clk); #1;
               i_valid_data = 1'b0;
            end
         end else begin
            @(posedge clk); #1;
         end
      end
   end

   initial begin
      int nv, nd;
      bit found;
      reset = 1'b1;
      i_start = 1'b0;
      i_kernel = '0;
      i_shift = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_pixel", int'(o_pixel), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_req", int'(o_read_request), 0);
      chk("rst_done", int'(o_frame_done), 0);
      reset = 1'b0;

      // Identity kernel on the ramp, with a long stall and spurious valids.
      fill_ramp(); set_kern_all(0); kern[4] = 1; shamt = 0;
      hold_first = 1'b1; spur_en = 1'b1;
      start_frame();
      wait_done("ident");
      hold_first = 1'b0; spur_en = 1'b0;
      chk("ident_first", got_at(0), 11);
      chk("ident_strip0_last", got_at(7), 81);
      chk("ident_strip1_first", got_at(8), 12);
      chk("ident_last", got_at(63), 88);

      // Box kernel, shift 1: first window sums to 99.
      fill_ramp(); set_kern_all(1); shamt = 1;
      start_frame();
      wait_done("box");
`ifdef CONV_ROUND_EN
      chk("box_first", got_at(0), 50);
`else
      chk("box_first", got_at(0), 49);
`endif

      // Upper saturation.
      fill_const(255); set_kern_all(1); shamt = 0;
      start_frame();
      wait_done("sat_hi");
      chk("sat_hi_first", got_at(0), 255);

      // Lower saturation.
      fill_rand(); set_kern_all(0); kern[4] = -1; shamt = 0;
      start_frame();
      wait_done("sat_lo");
      chk("sat_lo_last", got_at(63), 0);

      // Random kernels and images.
      for (int n = 0; n < 3; n++) begin
         fill_rand();
         for (int t = 0; t < 9; t++) kern[t] = int'($urandom_range(255)) - 128;
         shamt = int'($urandom_range(12));
         spur_en = bit'($urandom_range(1));
         start_frame();
         wait_done("rand");
      end
      spur_en = 1'b0;

      // Reset during strip 3 while a window compute is in flight.
      fill_ramp(); set_kern_all(0); kern[4] = 1; shamt = 0;
      start_frame();
      found = 1'b0;
      for (int c = 0; c < 3000 && !found; c++) begin
         @(negedge clk);
         if (req_cnt == 36 && o_read_request) found = 1'b1;
      end
      chk("abort_reach", int'(found), 1);
      reset = 1'b1;
      #1;
      gen++;
      chk("abort_valid", int'(o_valid), 0);
      chk("abort_pixel", int'(o_pixel), 0);
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_req", int'(o_read_request), 0);
      nv = 0; nd = 0;
      repeat (8) begin
         @(negedge clk);
         nv += int'(o_valid);
         nd += int'(o_frame_done);
      end
      reset = 1'b0;
      exp_q.delete();
      repeat (4) @(negedge clk);
      nv += int'(o_valid);
      nd += int'(o_frame_done);
      chk("abort_no_valid", nv, 0);
      chk("abort_no_done", nd, 0);

      start_frame();
      wait_done("post_abort");
      chk("post_abort_first", got_at(0), 11);
      chk("post_abort_strip1", got_at(8), 12);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
